// File: rtl/mips_mc_pkg.sv
// Shared encodings and types for the multi-cycle MIPS-subset core.
package mips_mc_pkg;

    localparam int unsigned REG_IDX_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2A;

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_t;
    typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_t;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                           (fn == FN_OR) || (fn == FN_SLT) || (fn == FN_SYSCALL);
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic alu_op_t alu_op_of(input logic [5:0] fn);
        alu_op_t op;
        case (fn)
            FN_SUB:  op = AluSub;
            FN_AND:  op = AluAnd;
            FN_OR:   op = AluOr;
            FN_SLT:  op = AluSlt;
            default: op = AluAdd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// 32x32 register file: two combinational reads, one synchronous write, r0 fixed at zero.
module mips_mc_regfile import mips_mc_pkg::*; (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [REG_IDX_W-1:0] raddr_a_i,
    input  logic [REG_IDX_W-1:0] raddr_b_i,
    input  logic                 we_i,
    input  logic [REG_IDX_W-1:0] waddr_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_a_o,
    output logic [31:0]          rdata_b_o
);

    logic [31:0] regs_q [32];

    // r0 is cleared by reset and never written, so it always reads zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS-subset core with a single req/ack memory port and halt/illegal reporting.
module mips_mc_core import mips_mc_pkg::*; #(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc_out,
    output logic              retire,
    output logic              halted,
    output logic              illegal
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_plus4_q, pc_plus4_d, ea_q, ea_d;
    logic [31:0]       ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [31:0]       res_q, res_d, mdr_q, mdr_d;
    alu_op_t           alu_op_q, alu_op_d;
    logic              req_q, req_d, halted_q, halted_d, illegal_q, illegal_d;

    logic [5:0]  opcode, funct;
    logic [31:0] rf_a, rf_b, op_b, alu_res, ea_full;
    logic        xfer, rf_we;

    assign opcode  = ir_q[31:26];
    assign funct   = ir_q[5:0];
    assign xfer    = req_q && mem_ack;
    assign op_b    = (opcode == OP_RTYPE) ? b_q : imm_q;
    assign ea_full = a_q + imm_q;
    assign rf_we   = (state_q == StWb);

    mips_mc_regfile u_regfile (
        .clk_i     (clk),
        .rst_i     (rst),
        .raddr_a_i (ir_q[25:21]),
        .raddr_b_i (ir_q[20:16]),
        .we_i      (rf_we),
        .waddr_i   ((opcode == OP_RTYPE) ? ir_q[15:11] : ir_q[20:16]),
        .wdata_i   ((opcode == OP_LW) ? mdr_q : res_q),
        .rdata_a_o (rf_a),
        .rdata_b_o (rf_b)
    );

    always_comb begin
        alu_res = '0;
        case (alu_op_q)
            AluAdd:  alu_res = a_q + op_b;
            AluSub:  alu_res = a_q - op_b;
            AluAnd:  alu_res = a_q & op_b;
            AluOr:   alu_res = a_q | op_b;
            AluSlt:  alu_res = {31'b0, $signed(a_q) < $signed(op_b)};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        res_d      = res_q;
        mdr_d      = mdr_q;
        ea_d       = ea_q;
        alu_op_d   = alu_op_q;
        req_d      = req_q;
        halted_d   = halted_q;
        illegal_d  = illegal_q;
        retire     = 1'b0;

        case (state_q)
            StFetch: begin
                if (xfer) begin
                    ir_d       = mem_rdata;
                    pc_plus4_d = pc_q + ADDR_W'(4);
                    req_d      = 1'b0;
                    state_d    = StDecode;
                end else begin
                    // Covers the first cycle after reset and the idle cycle after a store.
                    req_d = 1'b1;
                end
            end
            StDecode: begin
                a_d      = rf_a;
                b_d      = rf_b;
                imm_d    = {{16{ir_q[15]}}, ir_q[15:0]};
                alu_op_d = (opcode == OP_RTYPE) ? alu_op_of(funct) : AluAdd;
                if (is_legal(opcode, funct)) begin
                    state_d = StExec;
                end else begin
                    state_d   = StHalt;
                    halted_d  = 1'b1;
                    illegal_d = 1'b1;
                end
            end
            StExec: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_SYSCALL) begin
                            pc_d     = pc_plus4_q;
                            retire   = 1'b1;
                            halted_d = 1'b1;
                            state_d  = StHalt;
                        end else begin
                            res_d   = alu_res;
                            state_d = StWb;
                        end
                    end
                    OP_ADDI: begin
                        res_d   = alu_res;
                        state_d = StWb;
                    end
                    OP_LW, OP_SW: begin
                        if (ea_full[1:0] != 2'b00) begin
                            state_d   = StHalt;
                            halted_d  = 1'b1;
                            illegal_d = 1'b1;
                        end else begin
                            ea_d    = ea_full[ADDR_W-1:0];
                            req_d   = 1'b1;
                            state_d = StMem;
                        end
                    end
                    OP_BEQ: begin
                        pc_d    = (a_q == b_q) ? pc_plus4_q + ADDR_W'({imm_q[29:0], 2'b00})
                                               : pc_plus4_q;
                        retire  = 1'b1;
                        req_d   = 1'b1;
                        state_d = StFetch;
                    end
                    OP_J: begin
                        pc_d    = ADDR_W'((32'(pc_plus4_q) & 32'hF000_0000) |
                                          {4'b0, ir_q[25:0], 2'b00});
                        retire  = 1'b1;
                        req_d   = 1'b1;
                        state_d = StFetch;
                    end
                    default: begin
                        state_d   = StHalt;
                        halted_d  = 1'b1;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMem: begin
                if (xfer) begin
                    req_d = 1'b0;
                    if (opcode == OP_LW) begin
                        mdr_d   = mem_rdata;
                        state_d = StWb;
                    end else begin
                        pc_d    = pc_plus4_q;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            StWb: begin
                pc_d    = pc_plus4_q;
                retire  = 1'b1;
                req_d   = 1'b1;
                state_d = StFetch;
            end
            StHalt: begin
                req_d = 1'b0;
            end
            default: begin
                state_d = StHalt;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            pc_plus4_q <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            res_q      <= '0;
            mdr_q      <= '0;
            ea_q       <= '0;
            alu_op_q   <= AluAdd;
            req_q      <= 1'b0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            imm_q      <= imm_d;
            res_q      <= res_d;
            mdr_q      <= mdr_d;
            ea_q       <= ea_d;
            alu_op_q   <= alu_op_d;
            req_q      <= req_d;
            halted_q   <= halted_d;
            illegal_q  <= illegal_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = (state_q == StMem) && (opcode == OP_SW);
    assign mem_addr  = (state_q == StMem) ? ea_q : pc_q;
    assign mem_wdata = b_q;
    assign pc_out    = pc_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_mips_mc_core.sv
// Directed bench for mips_mc_core: programs in a wait-state memory model, checked by assertions.
module tb_mips_mc_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ack, retire, halted, illegal;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

    mips_mc_core #(
        .ADDR_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc_out    (pc_out),
        .retire    (retire),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    logic [31:0] image [256];
    logic [31:0] ram [256];
    logic [31:0] wr_addr [8];
    logic [31:0] wr_data [8];
    int          wr_n;
    int          wcnt;
    int          waits = 0;
    logic        stray_ack = 1'b0;
    int          checks = 0;
    int          errors = 0;

    assign mem_ack   = (mem_req && (wcnt >= waits)) || stray_ack;
    assign mem_rdata = ram[mem_addr[9:2]];

    // Memory model: reloads the program image while rst is high, logs every store.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= image[i];
            wr_n <= 0;
            wcnt <= 0;
        end else if (mem_req && mem_ack) begin
            wcnt <= 0;
            if (mem_we) begin
                ram[mem_addr[9:2]] <= mem_wdata;
                if (wr_n < 8) begin
                    wr_addr[wr_n] <= mem_addr;
                    wr_data[wr_n] <= mem_wdata;
                end
                wr_n <= wr_n + 1;
            end
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                          input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int tgt);
        return {6'h02, 26'(tgt)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_image();
        for (int i = 0; i < 256; i++) image[i] = 32'h0;
    endtask

    // Leaves the bench sampling the first cycle after release, where the first fetch is issued.
    task automatic start();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic run_until_halt(input string tag, input int limit, output int n_ret,
                                  output int n_req);
        int   c;
        logic prev;
        c     = 0;
        prev  = 1'b0;
        n_ret = 0;
        n_req = 0;
        while (!halted && c < limit) begin
            if (retire) n_ret++;
            if (mem_req && !prev) n_req++;
            prev = mem_req;
            tick();
            c++;
        end
        check({tag, "_halted"}, {31'b0, halted}, 32'h1);
    endtask

    task automatic wait_retire(input int limit, output int n);
        n = 0;
        while (!retire && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int          n_ret, n_req, n, cyc;
        int          sw_start, sw_end, lw_start, lw_end;
        logic        prev, bad;
        logic [15:0] rbits;

        // Basic ALU sequence, zero-wait memory.
        clear_image();
        image[0]  = enc_i(6'h08, 0, 1, 5);
        image[1]  = enc_i(6'h08, 0, 2, -3);
        image[2]  = enc_r(1, 2, 3, 6'h20);
        image[3]  = enc_r(2, 1, 4, 6'h2A);
        image[4]  = enc_r(1, 2, 5, 6'h22);
        image[5]  = enc_i(6'h08, 0, 7, 12);
        image[6]  = enc_r(1, 7, 6, 6'h24);
        image[7]  = enc_r(1, 7, 8, 6'h25);
        image[8]  = enc_r(1, 2, 9, 6'h2A);
        image[9]  = enc_i(6'h2B, 0, 3, 32'h80);
        image[10] = enc_i(6'h2B, 0, 4, 32'h84);
        image[11] = enc_i(6'h2B, 0, 5, 32'h88);
        image[12] = enc_i(6'h2B, 0, 6, 32'h8C);
        image[13] = enc_i(6'h2B, 0, 8, 32'h90);
        image[14] = enc_i(6'h2B, 0, 9, 32'h94);
        image[15] = enc_r(0, 0, 0, 6'h0C);
        waits = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_req", {31'b0, mem_req}, 32'h0);
        check("reset_pc", pc_out, 32'h0);
        check("reset_halted", {30'b0, halted, illegal}, 32'h0);
        start();
        check("t1_first_req", {30'b0, mem_req, mem_we}, 32'h2);
        check("t1_first_addr", mem_addr, 32'h0);
        for (int c = 0; c < 16; c++) begin
            rbits[c] = retire;
            tick();
        end
        check("t1_retire_cycles", {16'b0, rbits}, 32'h0000_8888);
        run_until_halt("t1", 300, n_ret, n_req);
        check("t1_retires", n_ret, 12);
        check("t1_illegal", {31'b0, illegal}, 32'h0);
        check("t1_pc", pc_out, 32'h40);
        check("t1_nwrites", wr_n, 6);
        check("t1_addr0", wr_addr[0], 32'h80);
        check("t1_add", wr_data[0], 32'h2);
        check("t1_slt_true", wr_data[1], 32'h1);
        check("t1_sub", wr_data[2], 32'h8);
        check("t1_and", wr_data[3], 32'h4);
        check("t1_or", wr_data[4], 32'hD);
        check("t1_slt_false", wr_data[5], 32'h0);
        check("t1_addr5", wr_addr[5], 32'h94);

        // Store/load round trip with 3 wait states on every ack.
        clear_image();
        image[0]  = enc_j(32'h10);
        image[16] = enc_i(6'h08, 0, 1, 5);
        image[17] = enc_i(6'h2B, 0, 1, 8);
        image[18] = enc_i(6'h23, 0, 5, 8);
        image[19] = enc_i(6'h2B, 0, 5, 32'h80);
        image[20] = enc_r(0, 0, 0, 6'h0C);
        waits = 3;
        start();
        prev = 1'b0;
        sw_start = -1; sw_end = -1; lw_start = -1; lw_end = -1;
        cyc = 1;
        while (!halted && cyc < 400) begin
            if (mem_req && !prev && !mem_we) begin
                if (mem_addr == 32'h44) sw_start = cyc;
                if (mem_addr == 32'h48) lw_start = cyc;
            end
            if (retire) begin
                if (sw_start >= 0 && sw_end < 0) sw_end = cyc;
                else if (lw_start >= 0 && lw_end < 0) lw_end = cyc;
            end
            prev = mem_req;
            tick();
            cyc++;
        end
        check("t2_halted", {31'b0, halted}, 32'h1);
        check("t2_sw_latency", sw_end - sw_start + 1, 10);
        check("t2_lw_latency", lw_end - lw_start + 1, 11);
        check("t2_nwrites", wr_n, 2);
        check("t2_sw_addr", wr_addr[0], 32'h8);
        check("t2_sw_data", wr_data[0], 32'h5);
        check("t2_lw_data", wr_data[1], 32'h5);
        check("t2_pc", pc_out, 32'h54);

        // Branches and jump, zero-wait.
        clear_image();
        image[0]  = enc_i(6'h08, 0, 1, 1);
        image[1]  = enc_i(6'h04, 1, 0, 5);
        image[2]  = enc_j(32'h40);
        image[64] = enc_i(6'h04, 1, 1, -1);
        waits = 0;
        start();
        wait_retire(20, n);
        check("t3_addi_latency", n + 1, 4);
        tick();
        check("t3_pc_addi", pc_out, 32'h4);
        wait_retire(20, n);
        check("t3_beq_nt_latency", n + 1, 3);
        tick();
        check("t3_pc_beq_nt", pc_out, 32'h8);
        wait_retire(20, n);
        check("t3_j_latency", n + 1, 3);
        tick();
        check("t3_pc_j", pc_out, 32'h100);
        for (int k = 0; k < 3; k++) begin
            wait_retire(20, n);
            check("t3_loop_latency", n + 1, 3);
            tick();
            check("t3_loop_pc", pc_out, 32'h100);
        end

        // Illegal opcode 0x3F.
        clear_image();
        image[0] = enc_i(6'h08, 0, 1, 1);
        image[1] = 32'hFC00_0000;
        start();
        run_until_halt("t4", 100, n_ret, n_req);
        check("t4_retires", n_ret, 1);
        check("t4_illegal", {31'b0, illegal}, 32'h1);
        check("t4_pc", pc_out, 32'h4);
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bad = bad | mem_req | retire;
            tick();
        end
        check("t4_quiet", {31'b0, bad}, 32'h0);
        check("t4_pc_frozen", pc_out, 32'h4);

        // Misaligned load address 6.
        clear_image();
        image[0] = enc_i(6'h08, 0, 1, 6);
        image[1] = enc_i(6'h23, 1, 2, 0);
        start();
        run_until_halt("t5", 100, n_ret, n_req);
        check("t5_illegal", {31'b0, illegal}, 32'h1);
        check("t5_pc", pc_out, 32'h4);
        check("t5_requests", n_req, 2);
        check("t5_retires", n_ret, 1);

        // Reset during a 10-wait fetch, then r0 write is discarded.
        clear_image();
        image[0] = enc_i(6'h08, 0, 0, 7);
        image[1] = enc_i(6'h2B, 0, 0, 32'h80);
        image[2] = enc_r(0, 0, 0, 6'h0C);
        waits = 10;
        start();
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t6_req_drop", {31'b0, mem_req}, 32'h0);
        check("t6_pc_reset", pc_out, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        check("t6_restart_req", {31'b0, mem_req}, 32'h1);
        check("t6_restart_addr", mem_addr, 32'h0);
        run_until_halt("t6", 400, n_ret, n_req);
        check("t6_retires", n_ret, 3);
        check("t6_nwrites", wr_n, 1);
        check("t6_r0_data", wr_data[0], 32'h0);
        check("t6_illegal", {31'b0, illegal}, 32'h0);
        check("t6_pc", pc_out, 32'hC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_mc_core.md
Name: mips_mc_core

Overview:
- Multi-cycle MIPS-subset core. Successor to the single-cycle top.
- Replaces the derived phase clocks with one clock and an FSM.
- Replaces the split ROM/RAM with one unified memory port that uses a req/ack handshake, so memories with variable wait states can be attached.
- Adds a halt/illegal-instruction mechanism and a retire pulse for the bench.

Parameters:
- ADDR_W, 32, byte-address width on the memory port and PC; legal range 8..32.
- RESET_PC, 0, PC loaded on reset; must be word-aligned.

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_req  out  1  memory request; held until ack
- mem_we  out  1  1 = write, 0 = read; stable while mem_req
- mem_addr  out  ADDR_W  byte address; stable while mem_req
- mem_wdata  out  32  store data; stable while mem_req
- mem_rdata  in  32  read data, sampled in the ack cycle
- mem_ack  in  1  transfer completes in any cycle where mem_req && mem_ack
- pc_out  out  ADDR_W  current instruction address
- retire  out  1  one-cycle pulse in the final cycle of each completed instruction
- halted  out  1  core stopped; sticky until rst
- illegal  out  1  halt was caused by an illegal or misaligned operation; sticky

Behaviour:
- Reset: all flops clear asynchronously.
  - pc = RESET_PC; state = FETCH.
  - mem_req, retire, halted and illegal = 0.
  - All 32 registers = 0.
  - First request is issued in the first cycle after rst deasserts.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - mem_req=1, we=0, addr=pc.
  - On ack: latch IR = mem_rdata and pc_plus4 = pc+4, then go to DECODE.
- DECODE:
  - Read rs/rt into A/B.
  - Sign-extend imm16 to 32 bits.
  - Classify the opcode. Unknown opcode or funct goes to HALT with illegal=1.
- EXEC:
  - R-type (op 0x00):
    - add 0x20 and sub 0x22: wrap modulo 2^32, no overflow trap.
    - and 0x24, or 0x25.
    - slt 0x2A: signed compare, result 1 or 0.
    - Next state WB, destination rd.
  - syscall (funct 0x0C): pc=pc_plus4, retire, then HALT with illegal=0.
  - addi (0x08): A+simm, next state WB, destination rt.
  - lw (0x23) / sw (0x2B):
    - Effective address = A+simm, truncated to ADDR_W.
    - If the low 2 bits are nonzero: HALT with illegal=1, no memory access.
    - Otherwise go to MEM.
  - beq (0x04): pc = (A==B) ? pc_plus4 + (simm<<2) : pc_plus4. Retire, then FETCH.
  - j (0x02): pc = {pc_plus4[ADDR_W-1:28] when ADDR_W>28, target26, 2'b00}, truncated to ADDR_W. Retire, then FETCH.
- MEM:
  - lw: req with we=0; on ack latch MDR, then WB.
  - sw: req with we=1 and wdata=B; on ack: pc=pc_plus4, retire, then FETCH.
- WB:
  - Write ALU result (R-type/addi) or MDR (lw) to the destination register.
  - pc=pc_plus4, retire, then FETCH.
- Writes to r0 are discarded; r0 always reads 0.
- Latency with zero-wait ack (ack in the same cycle as req):
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq and j: 3 cycles.
  - syscall: 3 cycles.
  - Each wait cycle adds 1 to FETCH or MEM.
- Handshake rules:
  - mem_req is registered; it deasserts the cycle after the ack.
  - mem_ack is ignored while mem_req=0.
  - Back-to-back requests never occur: MEM→FETCH has ≥1 idle cycle via state change.
- HALT: mem_req=0; pc_out frozen (at pc of offending instruction for illegal, pc_plus4 for syscall); no further retire. Only rst exits.
- Reset mid-transaction: mem_req drops asynchronously with rst; a late ack is ignored; no register or PC update from the aborted instruction.
- PC wrap-around: pc+4 wraps modulo 2^ADDR_W.

Decomposition:
- Package mips_mc_pkg holds:
  - Opcode and funct localparams.
  - state_t enum.
  - alu_op_t enum (ADD, SUB, AND, OR, SLT).
  - Reg index width constant (5).
- Sub-module mips_mc_regfile:
  - 32x32 storage with 2 combinational read ports and 1 synchronous write port.
  - Asynchronous reset; r0 hardwired to zero.
- ALU is inline in the core.

Test Plan:
- Basic sequence, zero-wait memory at RESET_PC=0:
  - Program: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1.
  - Expect $3=2 and $4=1, with retire at cycles 4, 8, 12, 16.
- Memory round trip with 3 wait states on every ack:
  - Program: sw $1,8($0), then lw $5,8($0).
  - Expect mem write at addr 8 with data 5, $5=5.
  - Expect lw = 5+6 = 11 cycles.
- Branches:
  - beq $1,$1,-1 loops: pc_out stays equal to the branch address across 3 retires.
  - beq not taken: pc advances by 4.
  - j 0x40: pc_out=0x100.
- Illegal opcode 0x3F:
  - Expect halted=1 and illegal=1.
  - pc_out equals the offending address; mem_req stays 0 for 20 cycles.
- Misaligned lw at address 6: halt with illegal=1, no mem_req in MEM.
- Reset during a 10-wait fetch:
  - Assert rst in wait cycle 4: mem_req drops that cycle, the later ack is ignored.
  - After release, fetch restarts at RESET_PC.
  - addi $0,$0,7 leaves $0=0.
